// File: rtl/pipeline_fetch_if.sv
// Instruction memory bus between the fetch stage (master) and a synchronous-read
// instruction memory (slave) with one cycle of read latency.
interface pipeline_fetch_if #(
    parameter int unsigned IR_W = 16
);
    logic [8:0]      imem_addr;
    logic [IR_W-1:0] imem_rdata;

    modport master (output imem_addr, input imem_rdata);
    modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/pipeline_fetch.sv
// Instruction fetch stage: fetch PC, one-entry skid for stalls, redirect flush, HALT freeze.
// Optional perf counters (fetch_count, stall_cycles) are built only with FETCH_PERF_EN.
module pipeline_fetch #(
    parameter int unsigned     PC_W      = 8,
    parameter int unsigned     IR_W      = 16,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter logic [IR_W-1:0] HALT_IR   = 16'hE000,
    parameter logic [IR_W-1:0] BUBBLE_IR = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                redirect,
    input  logic [PC_W-1:0]     redirect_pc,
    pipeline_fetch_if.master    imem,
    output logic [IR_W-1:0]     IR_out,
    output logic [PC_W-1:0]     PC_out,
    output logic                valid_out,
    output logic                halted,
    output logic [15:0]         fetch_count,
    output logic [15:0]         stall_cycles
);

    localparam logic [0:0] StRun  = 1'b0;
    localparam logic [0:0] StHalt = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;
    logic            inflight_valid_q, inflight_valid_d;
    logic [IR_W-1:0] skid_ir_q, skid_ir_d;
    logic [PC_W-1:0] skid_pc_q, skid_pc_d;
    logic            skid_valid_q, skid_valid_d;
    logic [IR_W-1:0] ir_q, ir_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic            load_valid;

    assign imem.imem_addr = 9'(fetch_pc_q);
    assign IR_out         = ir_q;
    assign PC_out         = pc_q;
    assign valid_out      = valid_q;
    assign halted         = (state_q == StHalt);

    always_comb begin
        state_d          = state_q;
        fetch_pc_d       = fetch_pc_q;
        inflight_pc_d    = inflight_pc_q;
        inflight_valid_d = inflight_valid_q;
        skid_ir_d        = skid_ir_q;
        skid_pc_d        = skid_pc_q;
        skid_valid_d     = skid_valid_q;
        ir_d             = ir_q;
        pc_d             = pc_q;
        valid_d          = valid_q;
        load_valid       = 1'b0;

        if (redirect) begin
            fetch_pc_d       = redirect_pc;
            inflight_valid_d = 1'b0;
            skid_valid_d     = 1'b0;
            valid_d          = 1'b0;
            ir_d             = BUBBLE_IR;
            pc_d             = '0;
            state_d          = StRun;
        end else if (stall) begin
            // Park the returning read so the held fetch_pc can be re-issued on release.
            if (inflight_valid_q && !skid_valid_q) begin
                skid_ir_d    = imem.imem_rdata;
                skid_pc_d    = inflight_pc_q;
                skid_valid_d = 1'b1;
            end
            inflight_valid_d = 1'b0;
        end else if (state_q == StHalt) begin
            inflight_valid_d = 1'b0;
            skid_valid_d     = 1'b0;
            valid_d          = 1'b0;
            ir_d             = BUBBLE_IR;
            pc_d             = '0;
        end else begin
            fetch_pc_d       = fetch_pc_q + PC_W'(1);
            inflight_pc_d    = fetch_pc_q;
            inflight_valid_d = 1'b1;
            if (skid_valid_q) begin
                ir_d         = skid_ir_q;
                pc_d         = skid_pc_q;
                valid_d      = 1'b1;
                skid_valid_d = 1'b0;
                load_valid   = 1'b1;
            end else begin
                valid_d    = inflight_valid_q;
                ir_d       = inflight_valid_q ? imem.imem_rdata : BUBBLE_IR;
                pc_d       = inflight_valid_q ? inflight_pc_q : '0;
                load_valid = inflight_valid_q;
            end
            if (load_valid && (ir_d == HALT_IR)) begin
                state_d          = StHalt;
                inflight_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= StRun;
            fetch_pc_q       <= RESET_PC;
            inflight_pc_q    <= '0;
            inflight_valid_q <= 1'b0;
            skid_ir_q        <= BUBBLE_IR;
            skid_pc_q        <= '0;
            skid_valid_q     <= 1'b0;
            ir_q             <= BUBBLE_IR;
            pc_q             <= '0;
            valid_q          <= 1'b0;
        end else begin
            state_q          <= state_d;
            fetch_pc_q       <= fetch_pc_d;
            inflight_pc_q    <= inflight_pc_d;
            inflight_valid_q <= inflight_valid_d;
            skid_ir_q        <= skid_ir_d;
            skid_pc_q        <= skid_pc_d;
            skid_valid_q     <= skid_valid_d;
            ir_q             <= ir_d;
            pc_q             <= pc_d;
            valid_q          <= valid_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [15:0] fetch_count_q, stall_cycles_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count_q  <= '0;
            stall_cycles_q <= '0;
        end else begin
            if (load_valid && (fetch_count_q != 16'hFFFF)) begin
                fetch_count_q <= fetch_count_q + 16'd1;
            end
            if (stall && (stall_cycles_q != 16'hFFFF)) begin
                stall_cycles_q <= stall_cycles_q + 16'd1;
            end
        end
    end

    assign fetch_count  = fetch_count_q;
    assign stall_cycles = stall_cycles_q;
`else
    assign fetch_count  = 16'h0000;
    assign stall_cycles = 16'h0000;
`endif

endmodule
